// File: rtl/adder_stream_driver.sv
// Initiator for the FIFO-buffered adder. Splits each command pair into independent A/B
// transfers, registers returned sums, and caps in-flight pairs with a credit counter.
module adder_stream_driver #(
  parameter int DATA_IN_WIDTH   = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_n,
  input  logic [2*DATA_IN_WIDTH-1:0] cmd_data,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  output logic [DATA_IN_WIDTH-1:0]   outA,
  output logic                       outA_valid,
  input  logic                       outA_ready,
  output logic [DATA_IN_WIDTH-1:0]   outB,
  output logic                       outB_valid,
  input  logic                       outB_ready,
  input  logic [DATA_IN_WIDTH:0]     sum_in,
  input  logic                       sum_in_valid,
  output logic                       sum_in_ready,
  output logic [DATA_IN_WIDTH:0]     rsp,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [7:0]                 outstanding_o,
  output logic [15:0]                rsp_count_o,
  output logic                       unexpected_o
);

  localparam int W = DATA_IN_WIDTH;
  localparam logic [7:0] MAX_CREDITS = 8'(MAX_OUTSTANDING);

  logic cmd_xfer;
  logic a_xfer;
  logic b_xfer;
  logic sum_xfer;
  logic rsp_xfer;

  // Readies depend only on registered state and the far side's ready, never on own valid.
  assign cmd_ready    = (!outA_valid | outA_ready) & (!outB_valid | outB_ready)
                      & (outstanding_o < MAX_CREDITS);
  assign sum_in_ready = !rsp_valid | rsp_ready;

  assign cmd_xfer = cmd_valid & cmd_ready;
  assign a_xfer   = outA_valid & outA_ready;
  assign b_xfer   = outB_valid & outB_ready;
  assign sum_xfer = sum_in_valid & sum_in_ready;
  assign rsp_xfer = rsp_valid & rsp_ready;

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      outA       <= '0;
      outA_valid <= 1'b0;
      outB       <= '0;
      outB_valid <= 1'b0;
    end else if (cmd_xfer) begin
      outA       <= cmd_data[2*W-1:W];
      outA_valid <= 1'b1;
      outB       <= cmd_data[W-1:0];
      outB_valid <= 1'b1;
    end else begin
      if (a_xfer) outA_valid <= 1'b0;
      if (b_xfer) outB_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      rsp       <= '0;
      rsp_valid <= 1'b0;
    end else if (sum_xfer) begin
      rsp       <= sum_in;
      rsp_valid <= 1'b1;
    end else if (rsp_xfer) begin
      rsp_valid <= 1'b0;
    end
  end

  // A sum with no credit in flight is still forwarded; it only flags the anomaly.
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      outstanding_o <= '0;
      rsp_count_o   <= '0;
      unexpected_o  <= 1'b0;
    end else begin
      if (sum_xfer) rsp_count_o <= rsp_count_o + 16'd1;
      case ({cmd_xfer, sum_xfer})
        2'b10:   outstanding_o <= outstanding_o + 8'd1;
        2'b01: begin
          if (outstanding_o != 8'd0) outstanding_o <= outstanding_o - 8'd1;
          else                       unexpected_o  <= 1'b1;
        end
        default: outstanding_o <= outstanding_o;
      endcase
    end
  end

endmodule
